// File: rtl/hazard_stall_unit.sv
// Load-use stall and branch-flush control for a 5-stage pipeline.
// Tracks the instructions in EX and MEM; only loads stall, ALU results are forwarded.
module hazard_stall_unit #(
  parameter int unsigned REG_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_use_rs,
  input  logic             id_use_rd,
  input  logic             id_regwrite,
  input  logic [REG_W-1:0] id_wdst,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StLstall = 2'd1,
    StFlush  = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             is_load;
    logic [REG_W-1:0] dst;
  } sb_entry_t;

  sb_entry_t        ex_q, ex_d;
  sb_entry_t        mem_q, mem_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic ex_hit, mem_hit, load_hazard;

  always_comb begin
    ex_hit  = ex_q.valid & ex_q.regwrite & ex_q.is_load &
              ((id_use_rs & (ex_q.dst == id_rs)) | (id_use_rd & (ex_q.dst == id_rd)));
    mem_hit = mem_q.valid & mem_q.regwrite & mem_q.is_load &
              ((id_use_rs & (mem_q.dst == id_rs)) | (id_use_rd & (mem_q.dst == id_rd)));
    load_hazard = id_valid & (ex_hit | mem_hit);
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_d     = StRun;
    stall_cnt_d = stall_cnt_q;

    // A taken branch squashes the stalled instruction anyway, so it wins over a load hazard.
    if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StFlush;
    end else if (load_hazard) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = StLstall;
      if (stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end

    mem_d = ex_q;
    if (!idex_bubble && id_valid) begin
      ex_d = '{valid: 1'b1, regwrite: id_regwrite, is_load: id_is_load, dst: id_wdst};
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      state_q     <= StRun;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_stall_unit.md
HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-address width (8 general registers).
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports id_rs, id_rd  input  REG_W each  source register fields of the ID instruction.
REQ-007 SHALL have ports id_use_rs, id_use_rd  input  1 each  the corresponding field is read as a source.
REQ-008 SHALL have port id_regwrite  input  1  ID instruction writes a register.
REQ-009 SHALL have port id_wdst  input  REG_W  destination register of the ID instruction.
REQ-010 SHALL have port id_is_load  input  1  ID instruction is a load (data valid only after MEM).
REQ-011 SHALL have port ex_br_taken  input  1  branch resolved taken in EX this cycle.
REQ-012 SHALL have port pc_we  output  1  PC write enable.
REQ-013 SHALL have port ifid_we  output  1  IF/ID register write enable.
REQ-014 SHALL have port ifid_flush  output  1  IF/ID register cleared to NOP.
REQ-015 SHALL have port idex_bubble  output  1  ID/EX register loaded with NOP.
REQ-016 SHALL have port state  output  2  FSM state: 0 RUN, 1 LSTALL, 2 FLUSH.
REQ-017 SHALL have port stall_cnt  output  CNT_W  count of load-stall cycles.

Function
REQ-018 SHALL keep a two-entry scoreboard (EX slot, MEM slot), each entry {valid, regwrite, is_load, dst}, mirroring the pipeline.
REQ-019 Each cycle the MEM slot SHALL take the EX slot value; the EX slot SHALL take the ID fields when idex_bubble=0 and id_valid=1, else become invalid.
REQ-020 Load hazard SHALL be: (EX slot or MEM slot) valid & regwrite & is_load & dst equals id_rs (with id_use_rs) or id_rd (with id_use_rd), gated by id_valid.
REQ-021 Non-load producers SHALL NOT cause a stall (covered by forwarding).
REQ-022 On load hazard without ex_br_taken: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, next state LSTALL, stall_cnt increments.
REQ-023 A load in EX SHALL therefore yield exactly 2 stall cycles; a load in MEM exactly 1.
REQ-024 On ex_br_taken: ifid_flush=1, idex_bubble=1, pc_we=1, ifid_we=1, next state FLUSH; ex_br_taken SHALL override a simultaneous load hazard and SHALL NOT increment stall_cnt.
REQ-025 With neither condition: pc_we=1, ifid_we=1, flush=0, bubble=0, next state RUN.
REQ-026 Outputs SHALL be combinational from scoreboard and current inputs; state and stall_cnt registered.
REQ-027 stall_cnt SHALL saturate at all-ones.
REQ-028 Register 0 SHALL be compared like any other register (no hardwired-zero exemption).

Reset
REQ-029 rst_n low SHALL immediately clear both scoreboard entries, state=RUN, stall_cnt=0; outputs then pc_we=1, ifid_we=1, ifid_flush=0, idex_bubble=0 (absent ex_br_taken).
REQ-030 Reset asserted mid-stall SHALL abort the stall; first cycle after release SHALL be RUN with no stall.

Verification
REQ-031 Load r3 into ID, next ID instruction reads rs=3 -> two cycles pc_we=0, idex_bubble=1, state LSTALL, stall_cnt=2, then RUN.
REQ-032 ALU write r3, next instruction reads r3 -> no stall, pc_we=1 every cycle, stall_cnt=0.
REQ-033 Load r5, one independent instruction, then reader of rd=5 -> exactly 1 stall cycle.
REQ-034 Load hazard and ex_br_taken in same cycle -> ifid_flush=1, idex_bubble=1, pc_we=1, state FLUSH, stall_cnt unchanged.
REQ-035 rst_n pulsed low during first stall cycle -> outputs return to run values at once, stall_cnt=0, no stall after release.
REQ-036 stall_cnt preloaded near max via repeated load-use -> holds at 16'hFFFF.
